scene_mem_responder: RTL and testbench
======================================

SCENE_MEM_RESPONDER -- requirements
Module: scene_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, halfword-index width (depth 2**ADDR_W 16-bit words).
REQ-002 SHALL have parameter RD_LAT, default 2, read latency in cycles, legal range 1..4.
REQ-003 SHALL have parameter OOR_DATA, default 16'hDEAD, readdata returned for out-of-range reads.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 avs_s0_address  input  32  byte address from the master; halfword index = address[ADDR_W:1].
REQ-007 avs_s0_read  input  1  read request.
REQ-008 avs_s0_write  input  1  write request.
REQ-009 avs_s0_writedata  input  16  write data.
REQ-010 avs_s0_byteenable  input  2  per-byte write enable; ignored for reads.
REQ-011 avs_s0_readdata  output  16  read return data.
REQ-012 avs_s0_readdatavalid  output  1  readdata qualifier, one pulse per accepted read.
REQ-013 avs_s0_waitrequest  output  1  stall; request not accepted while high.
REQ-014 ld_en  input  1  host preload strobe (scene loading).
REQ-015 ld_addr  input  ADDR_W  preload halfword index.
REQ-016 ld_data  input  16  preload data, full word written.
REQ-017 wr_count  output  16  number of accepted avs_s0 writes since reset, saturating at 16'hFFFF.

Function
REQ-018 A request SHALL be accepted on a rising edge where (read or write) is high and waitrequest is low.
REQ-019 waitrequest SHALL be combinationally high exactly when ld_en is high; loader has priority over the bus.
REQ-020 Master SHALL hold address/read/write/data stable while waitrequest is high; responder samples only on acceptance.
REQ-021 An accepted read SHALL produce readdatavalid high exactly RD_LAT cycles after the acceptance edge, with the addressed word.
REQ-022 Reads SHALL be fully pipelined: one accepted read per cycle, returns in order, back-to-back valid cycles for back-to-back reads.
REQ-023 Read pipeline SHALL be a RD_LAT-deep shift of {valid, data}; no other read state; no stall on the return path.
REQ-024 readdata SHALL be 16'h0000 in any cycle readdatavalid is low.
REQ-025 Address with any bit above ADDR_W set (byte address >= 2**(ADDR_W+1)) SHALL be out of range: reads return OOR_DATA with normal latency; writes discarded but counted.
REQ-026 Accepted write SHALL update byte [7:0] if byteenable[0], byte [15:8] if byteenable[1]; byteenable 2'b00 writes nothing but is counted.
REQ-027 Read and write asserted together SHALL be treated as a write only; no readdatavalid generated.
REQ-028 Read accepted one cycle after a write to the same address SHALL return the new data (write-first ordering).
REQ-029 Preload with ld_en high SHALL write ld_data to ld_addr on that edge; preload never generates readdatavalid and never increments wr_count.
REQ-030 Reads already in the pipeline when ld_en rises SHALL still complete at their scheduled cycle.
REQ-031 address[0] SHALL be ignored (halfword aligned).

Reset
REQ-032 reset low SHALL asynchronously clear readdatavalid, readdata, the read pipeline and wr_count to 0; in-flight reads are dropped, never returned.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 waitrequest SHALL follow REQ-019 during reset; no request is accepted while reset is low.

Verification
REQ-035 Preload index 0..11 with 0x0000,0x0000,0x0000,0x0000,0x0000,0x0001,0x0000,0x0000,0x0000,0x0000,0x0000,0xFFFF; 12 back-to-back reads at byte address 0,2..22 -> 12 consecutive readdatavalid cycles starting RD_LAT after first accept, data in that order.
REQ-036 Write 0xABCD to byte addr 0x20 with byteenable 2'b01 over stored 0x1234, then read -> 0x12CD; wr_count = 1.
REQ-037 Read pending, ld_en high for 3 cycles during next read -> waitrequest high 3 cycles, pending read returns on schedule, held read accepted after ld_en falls, no duplicate valid.
REQ-038 Read at byte address 2**(ADDR_W+1) -> readdatavalid after RD_LAT with 16'hDEAD.
REQ-039 Issue 2 reads then pull reset low 1 cycle later -> no readdatavalid after reset; memory word re-read after reset returns pre-reset value.
REQ-040 Read and write asserted same cycle to addr 4 with 0x5555 -> no readdatavalid, subsequent read of addr 4 returns 0x5555.

Source files
------------

// File: rtl/scene_mem_responder.sv
// scene_mem_responder
//
// Purpose:
//   Avalon-MM slave front end for a 16-bit scene memory. Reads are fully
//   pipelined with a fixed latency of RD_LAT cycles. Writes can update
//   individual bytes. A host-side loader port preloads scene data and has
//   priority over the bus: while it is active, the bus is stalled.
//
// Parameters:
//   ADDR_W   - halfword index width; the memory holds 2**ADDR_W 16-bit words
//   RD_LAT   - read latency in cycles (1..4)
//   OOR_DATA - data returned for reads beyond the memory
//
// Ports:
//   clk                  - system clock, rising edge
//   reset                - asynchronous active-low reset
//   avs_s0_address       - byte address; halfword index is address[ADDR_W:1]
//   avs_s0_read          - read request
//   avs_s0_write         - write request (wins if read is also high)
//   avs_s0_writedata     - write data
//   avs_s0_byteenable    - per-byte write enable
//   avs_s0_readdata      - read return data, zero when not valid
//   avs_s0_readdatavalid - one pulse per accepted read
//   avs_s0_waitrequest   - stall, high exactly while ld_en is high
//   ld_en                - preload strobe
//   ld_addr              - preload halfword index
//   ld_data              - preload data, full word
//   wr_count             - accepted bus writes since reset, saturating

module scene_mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          RD_LAT   = 2,
    parameter logic [15:0] OOR_DATA = 16'hDEAD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [15:0]       avs_s0_writedata,
    input  logic [1:0]        avs_s0_byteenable,
    output logic [15:0]       avs_s0_readdata,
    output logic              avs_s0_readdatavalid,
    output logic              avs_s0_waitrequest,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] index;
    logic              in_range;
    logic              accept;
    logic              wr_accept;
    logic              rd_accept;
    logic [15:0]       rd_word;
    logic              unused_addr_lsb;

    logic              pipe_valid [RD_LAT];
    logic [15:0]       pipe_data  [RD_LAT];

    // Bit 0 of the byte address never selects anything: accesses are
    // halfword aligned.
    assign unused_addr_lsb = avs_s0_address[0];

    assign index    = avs_s0_address[ADDR_W:1];
    assign in_range = (avs_s0_address[31:ADDR_W+1] == '0);

    // The loader owns the memory whenever ld_en is high, so the bus is
    // stalled for exactly that time. Nothing is accepted during reset.
    assign avs_s0_waitrequest = ld_en;
    assign accept    = (avs_s0_read | avs_s0_write) & ~ld_en & reset;
    assign wr_accept = accept & avs_s0_write;
    assign rd_accept = accept & avs_s0_read & ~avs_s0_write;

    // Reads sample the array as it stands before this edge's update, so a
    // write on the previous edge is already visible (write-first order).
    assign rd_word = in_range ? mem[index] : OOR_DATA;

    // Memory array: no reset, so contents survive reset. Out-of-range
    // bus writes are dropped here but still counted below.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (wr_accept && in_range) begin
            if (avs_s0_byteenable[0]) begin
                mem[index][7:0] <= avs_s0_writedata[7:0];
            end
            if (avs_s0_byteenable[1]) begin
                mem[index][15:8] <= avs_s0_writedata[15:8];
            end
        end
    end

    // Read return path: a plain shift of {valid, data}, one stage per cycle
    // of latency. Data is zeroed in empty slots so the output needs no mux.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= 16'h0000;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            pipe_data[0]  <= rd_accept ? rd_word : 16'h0000;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign avs_s0_readdatavalid = pipe_valid[RD_LAT-1];
    assign avs_s0_readdata      = pipe_data[RD_LAT-1];

    // Write counter includes out-of-range and zero-byteenable writes and
    // sticks at all ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count <= 16'h0000;
        end else if (wr_accept && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_scene_mem_responder.sv
// tb_scene_mem_responder
//
// Purpose:
//   Directed self-checking bench for scene_mem_responder with default
//   parameters. Inputs change 1 ns after the rising edge; outputs are
//   checked at that same point, so they reflect the edge just taken.
//
// Ports: none (top-level bench).

module tb_scene_mem_responder;

    localparam int          ADDR_W   = 10;
    localparam int          RD_LAT   = 2;
    localparam logic [15:0] OOR_DATA = 16'hDEAD;

    logic              clk;
    logic              reset;
    logic [31:0]       address;
    logic              read;
    logic              write;
    logic [15:0]       writedata;
    logic [1:0]        byteenable;
    logic [15:0]       readdata;
    logic              readdatavalid;
    logic              waitrequest;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [15:0]       ld_data;
    logic [15:0]       wr_count;

    int assert_count;
    int fail_count;

    logic [15:0] scene [12];

    scene_mem_responder #(
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .OOR_DATA (OOR_DATA)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .avs_s0_address       (address),
        .avs_s0_read          (read),
        .avs_s0_write         (write),
        .avs_s0_writedata     (writedata),
        .avs_s0_byteenable    (byteenable),
        .avs_s0_readdata      (readdata),
        .avs_s0_readdatavalid (readdatavalid),
        .avs_s0_waitrequest   (waitrequest),
        .ld_en                (ld_en),
        .ld_addr              (ld_addr),
        .ld_data              (ld_data),
        .wr_count             (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Single read: accept, then no valid until the scheduled cycle, exactly
    // one valid cycle with the expected word, then quiet again.
    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [15:0] expected);
        address = addr;
        read    = 1'b1;
        tick();
        read = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            check_output({tag, "_early_valid"}, {31'd0, readdatavalid}, 32'd0);
            tick();
        end
        check_output({tag, "_valid"}, {31'd0, readdatavalid}, 32'd1);
        check_output({tag, "_data"}, {16'd0, readdata}, {16'd0, expected});
        tick();
        check_output({tag, "_no_dup"}, {31'd0, readdatavalid}, 32'd0);
        check_output({tag, "_data_zero"}, {16'd0, readdata}, 32'd0);
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        scene = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};

        reset      = 1'b0;
        address    = 32'd0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 16'h0000;
        byteenable = 2'b00;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = 16'h0000;

        // Reset state
        tick();
        tick();
        check_output("rst_valid", {31'd0, readdatavalid}, 32'd0);
        check_output("rst_data", {16'd0, readdata}, 32'd0);
        check_output("rst_wr_count", {16'd0, wr_count}, 32'd0);
        check_output("rst_waitreq_low", {31'd0, waitrequest}, 32'd0);
        ld_en = 1'b1;
        #1;
        check_output("rst_waitreq_high", {31'd0, waitrequest}, 32'd1);
        ld_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Preload the scene; the bus is stalled throughout
        for (int i = 0; i < 12; i++) begin
            ld_en   = 1'b1;
            ld_addr = ADDR_W'(i);
            ld_data = scene[i];
            #1;
            check_output("preload_waitreq", {31'd0, waitrequest}, 32'd1);
            tick();
        end
        ld_addr = ADDR_W'(16);
        ld_data = 16'h1234;
        tick();
        ld_en = 1'b0;
        #1;
        check_output("preload_no_valid", {31'd0, readdatavalid}, 32'd0);
        check_output("preload_no_count", {16'd0, wr_count}, 32'd0);

        // Twelve back-to-back reads, returns in order on consecutive cycles
        for (int c = 0; c < 12 + RD_LAT; c++) begin
            read    = (c < 12);
            address = 32'(2 * c);
            tick();
            if (c >= RD_LAT - 1 && c - (RD_LAT - 1) < 12) begin
                check_output("burst_valid", {31'd0, readdatavalid}, 32'd1);
                check_output("burst_data", {16'd0, readdata},
                             {16'd0, scene[c - (RD_LAT - 1)]});
            end else begin
                check_output("burst_idle_valid", {31'd0, readdatavalid}, 32'd0);
                check_output("burst_idle_data", {16'd0, readdata}, 32'd0);
            end
        end
        read = 1'b0;

        // Low-byte write over 0x1234, read the next cycle -> 0x12CD
        address    = 32'h20;
        write      = 1'b1;
        writedata  = 16'hABCD;
        byteenable = 2'b01;
        tick();
        write = 1'b0;
        do_read("byte_write", 32'h20, 16'h12CD);
        check_output("byte_write_count", {16'd0, wr_count}, 32'd1);

        // Read and write together: write only
        address    = 32'd4;
        read       = 1'b1;
        write      = 1'b1;
        writedata  = 16'h5555;
        byteenable = 2'b11;
        tick();
        read  = 1'b0;
        write = 1'b0;
        for (int i = 0; i < RD_LAT + 1; i++) begin
            check_output("rw_no_valid", {31'd0, readdatavalid}, 32'd0);
            tick();
        end
        do_read("rw_readback", 32'd4, 16'h5555);
        check_output("rw_count", {16'd0, wr_count}, 32'd2);

        // Out-of-range read and write (write aliases index 0 if not dropped)
        do_read("oor_read", 32'(1 << (ADDR_W + 1)), OOR_DATA);
        address    = 32'(1 << (ADDR_W + 1));
        write      = 1'b1;
        writedata  = 16'h7777;
        byteenable = 2'b11;
        tick();
        write = 1'b0;
        check_output("oor_write_count", {16'd0, wr_count}, 32'd3);
        do_read("oor_write_dropped", 32'd0, 16'h0000);

        // Loader interrupts a held read while another read is in flight
        address = 32'd10;
        read    = 1'b1;
        tick();
        check_output("ld_k0_valid", {31'd0, readdatavalid}, {31'd0, RD_LAT == 1});
        address = 32'd22;
        ld_addr = ADDR_W'(100);
        ld_data = 16'h4242;
        for (int k = 1; k <= 8; k++) begin
            ld_en = (k <= 3);
            read  = (k <= 4);
            #1;
            check_output("ld_waitreq", {31'd0, waitrequest}, {31'd0, k <= 3});
            tick();
            if (k == RD_LAT - 1) begin
                check_output("ld_pending_valid", {31'd0, readdatavalid}, 32'd1);
                check_output("ld_pending_data", {16'd0, readdata}, 32'h0001);
            end else if (k == 3 + RD_LAT) begin
                check_output("ld_held_valid", {31'd0, readdatavalid}, 32'd1);
                check_output("ld_held_data", {16'd0, readdata}, 32'hFFFF);
            end else begin
                check_output("ld_idle_valid", {31'd0, readdatavalid}, 32'd0);
            end
        end
        check_output("ld_count", {16'd0, wr_count}, 32'd3);
        do_read("ld_word", 32'd200, 16'h4242);

        // Reset with reads in flight; memory survives, nothing returns
        address = 32'd10;
        read    = 1'b1;
        tick();
        address = 32'd22;
        tick();
        read  = 1'b0;
        reset = 1'b0;
        #1;
        check_output("mid_rst_valid", {31'd0, readdatavalid}, 32'd0);
        check_output("mid_rst_data", {16'd0, readdata}, 32'd0);
        check_output("mid_rst_count", {16'd0, wr_count}, 32'd0);
        address    = 32'd0;
        write      = 1'b1;
        writedata  = 16'h9999;
        byteenable = 2'b11;
        tick();
        check_output("rst_write_blocked_cnt", {16'd0, wr_count}, 32'd0);
        write = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < RD_LAT + 2; i++) begin
            tick();
            check_output("post_rst_no_valid", {31'd0, readdatavalid}, 32'd0);
        end
        do_read("post_rst_mem", 32'd10, 16'h0001);
        do_read("rst_write_blocked", 32'd0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
